qr_unmask: RTL and testbench
============================

QR_UNMASK -- requirements
Module: qr_unmask

Interface
REQ-001 SHALL have parameter CODE_SIZE, default 21, giving the grid side in modules (version-1 QR only).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port qr_code_in, input, 441 bits: combined grid; module (x=col, y=row) at bit x + y*21; 1 = dark.
REQ-005 SHALL have port valid_in, input, 1 bit: qr_code_in is valid this cycle.
REQ-006 SHALL have port ready_out, output, 1 bit: block is idle and accepts a grid.
REQ-007 SHALL have port qr_unmasked_out, output, 441 bits: unmasked grid, same indexing as qr_code_in.
REQ-008 SHALL have port mask_out, output, 3 bits: decoded mask pattern ID.
REQ-009 SHALL have port ecc_level_out, output, 2 bits: decoded ECC level (01 L, 00 M, 11 Q, 10 H).
REQ-010 SHALL have port valid_out, output, 1 bit: outputs are valid.
REQ-011 SHALL have port ready_in, input, 1 bit: downstream accepts the outputs.
REQ-012 SHALL have port format_error_out, output, 1 bit: the two format copies disagree.

Function
REQ-013 SHALL implement states IDLE, FORMAT, UNMASK and DONE; ready_out = (state == IDLE).
REQ-014 In IDLE, valid_in && ready_out SHALL capture qr_code_in into an internal grid register, clear the counters and enter FORMAT.
REQ-015 FORMAT SHALL last exactly 15 cycles, shifting one format bit per cycle, MSB first, from copy A.
- Copy A positions (x,y): (0..5,8), (7,8), (8,8), (8,7), (8,5..0).
REQ-016 On leaving FORMAT, the block SHALL XOR the 15-bit word with 15'b101010000010010.
- ecc_level_out = bits[14:13]; mask_out = bits[12:10].
REQ-017 UNMASK SHALL last exactly 21 cycles, processing row y = 0..20, one row per cycle.
- Each data module (non-function module) with mask condition true SHALL be inverted.
- Function modules SHALL be copied unchanged.
REQ-018 Mask conditions (i = row, j = col):
- 0: (i+j)%2 == 0
- 1: i%2 == 0
- 2: j%3 == 0
- 3: (i+j)%3 == 0
- 4: (i/2 + j/3)%2 == 0
- 5: (i*j)%2 + (i*j)%3 == 0
- 6: ((i*j)%2 + (i*j)%3)%2 == 0
- 7: ((i+j)%2 + (i*j)%3)%2 == 0
REQ-019 Function modules SHALL be:
- rows 0-8 × cols 0-8; rows 0-8 × cols 13-20; rows 13-20 × cols 0-8;
- row 6; col 6.
REQ-020 valid_out SHALL assert exactly 37 cycles after the accepting edge (1 + 15 + 21), entering DONE.
REQ-021 In DONE, all outputs SHALL be held stable while ready_in = 0; valid_out && ready_in SHALL return to IDLE the next cycle with valid_out = 0.
REQ-022 valid_in SHALL be ignored while not IDLE; outputs SHALL keep their last values until the next completion.

Reset
REQ-023 rst_in = 1 SHALL force state IDLE and clear all counters in the same edge, in any state, including mid-FORMAT or mid-UNMASK.
REQ-024 Reset values: valid_out 0, qr_unmasked_out 0, mask_out 0, ecc_level_out 0, format_error_out 0; ready_out SHALL be 1 the cycle after reset.

Configuration
REQ-025 With FORMAT_CHECK_EN defined, FORMAT SHALL also shift copy B in parallel.
- Copy B positions: (8,20..14), then (13..20,8).
- format_error_out SHALL be set with valid_out when copy A ≠ copy B (raw bits).
- Decoding SHALL always use copy A.
REQ-026 Without FORMAT_CHECK_EN, copy B logic SHALL be absent and format_error_out SHALL be tied to 0.

Structure
REQ-027 Package qr_pkg SHALL hold CODE_SIZE, the format XOR constant, the state enum, the copy A/B coordinate tables and the 441-bit function-module map.
REQ-028 Combinational sub-module qr_mask_row SHALL produce the 21-bit row mask from (mask ID, row index, function-map row).

Verification
REQ-029 All-zero grid -> mask_out 5, ecc_level_out 2'b10.
- Bit (x=12,y=9) = 1; bit (9,9) = 0; row 6 all 0.
- valid_out at cycle 37.
REQ-030 Copy A raw 15'b111011111000100, rest 0 -> ecc_level_out 2'b01, mask_out 0.
- Bit (9,9) = 1; bit (10,9) = 0.
REQ-031 ready_in held 0 for 10 cycles in DONE -> valid_out and outputs stable, ready_out 0, a pulsed valid_in ignored.
- ready_in = 1 -> IDLE next cycle.
REQ-032 rst_in at cycle 20 after accept -> next cycle valid_out 0, outputs 0, ready_out 1.
- A new grid then completes in 37 cycles.
REQ-033 FORMAT_CHECK_EN defined, copy B bit 3 flipped -> format_error_out 1 with valid_out; mask_out taken from copy A.
REQ-034 Back-to-back: ready_in = 1 at valid_out, second grid presented -> accepted on the first IDLE cycle, second valid_out 38 cycles after the first.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared constants for the version-1 QR unmasker: grid size, format XOR word, FSM states,
// format-copy coordinate tables and the function-module map.
package qr_pkg;

  localparam int CODE_SIZE = 21;
  localparam int GRID_BITS = CODE_SIZE * CODE_SIZE;

  localparam logic [14:0] FMT_XOR = 15'b101010000010010;

  typedef enum logic [1:0] {IDLE, FORMAT, UNMASK, DONE} state_e;

  // Format copies, listed in shift order (first entry lands in bit 14).
  localparam logic [4:0] FMT_A_X [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8,
                                         5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8};
  localparam logic [4:0] FMT_A_Y [15] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8,
                                         5'd7, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
  localparam logic [4:0] FMT_B_X [15] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd13,
                                         5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
  localparam logic [4:0] FMT_B_Y [15] = '{5'd20, 5'd19, 5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd8,
                                         5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8};

  function automatic logic [8:0] grid_idx(input logic [4:0] x, input logic [4:0] y);
    return 9'(x) + 9'(y) * 9'(CODE_SIZE);
  endfunction

  function automatic logic [GRID_BITS-1:0] build_func_map();
    logic [GRID_BITS-1:0] m;
    m = '0;
    for (int y = 0; y < CODE_SIZE; y++) begin
      for (int x = 0; x < CODE_SIZE; x++) begin
        if ((y <= 8 && x <= 8) || (y <= 8 && x >= 13) || (y >= 13 && x <= 8) ||
            y == 6 || x == 6)
          m[x + y * CODE_SIZE] = 1'b1;
      end
    end
    return m;
  endfunction

  // Finder patterns with separators/format areas, plus both timing lines.
  localparam logic [GRID_BITS-1:0] FUNC_MAP = build_func_map();

endpackage

// File: rtl/qr_mask_row.sv
// Combinational row mask: bit j set when module (row_i, j) is a data module whose mask condition holds.
module qr_mask_row
  import qr_pkg::*;
(
  input  logic [2:0]           mask_id_i,
  input  logic [4:0]           row_i,
  input  logic [CODE_SIZE-1:0] func_row_i,
  output logic [CODE_SIZE-1:0] mask_row_o
);

  always_comb begin
    int  i;
    int  ij;
    logic cond;
    mask_row_o = '0;
    i          = int'(row_i);
    ij         = 0;
    cond       = 1'b0;
    for (int j = 0; j < CODE_SIZE; j++) begin
      ij = i * j;
      case (mask_id_i)
        3'd0:    cond = ((i + j) % 2) == 0;
        3'd1:    cond = (i % 2) == 0;
        3'd2:    cond = (j % 3) == 0;
        3'd3:    cond = ((i + j) % 3) == 0;
        3'd4:    cond = ((i / 2 + j / 3) % 2) == 0;
        3'd5:    cond = ((ij % 2) + (ij % 3)) == 0;
        3'd6:    cond = (((ij % 2) + (ij % 3)) % 2) == 0;
        default: cond = ((((i + j) % 2) + (ij % 3)) % 2) == 0;
      endcase
      mask_row_o[j] = cond & ~func_row_i[j];
    end
  end

endmodule

// File: rtl/qr_unmask.sv
// QR v1 unmasker: accept grid, read format (15 cyc), unmask one row/cycle (21 cyc), hold result until ready_in.
// valid_out 37 cycles after the accept cycle; ignores valid_in when busy. FORMAT_CHECK_EN adds copy-B compare.
module qr_unmask #(
  parameter int CODE_SIZE = 21
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [CODE_SIZE*CODE_SIZE-1:0] qr_code_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [CODE_SIZE*CODE_SIZE-1:0] qr_unmasked_out,
  output logic [2:0]                     mask_out,
  output logic [1:0]                     ecc_level_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           format_error_out
);
  import qr_pkg::*;

  localparam int GRID = CODE_SIZE * CODE_SIZE;
  localparam logic [4:0] LAST_FMT = 5'd14;
  localparam logic [4:0] LAST_ROW = 5'(CODE_SIZE - 1);

  state_e              state_q;
  logic [GRID-1:0]     grid_q, grid_d, out_q;
  logic [4:0]          cnt_q;
  logic [14:0]         fmt_a_q;
  logic [2:0]          mask_q, mask_id;
  logic [1:0]          ecc_q, ecc_id;
  logic                valid_q;
  logic                fmt_a_bit;
  logic [8:0]          row_base;
  logic [CODE_SIZE-1:0] row_mask;

  assign fmt_a_bit = grid_q[grid_idx(FMT_A_X[cnt_q[3:0]], FMT_A_Y[cnt_q[3:0]])];
  // fmt_a_q holds the complete raw copy A for the whole UNMASK phase.
  assign mask_id   = fmt_a_q[12:10] ^ FMT_XOR[12:10];
  assign ecc_id    = fmt_a_q[14:13] ^ FMT_XOR[14:13];
  assign row_base  = 9'(int'(cnt_q) * CODE_SIZE);

  qr_mask_row u_mask_row (
    .mask_id_i  (mask_id),
    .row_i      (cnt_q),
    .func_row_i (FUNC_MAP[row_base +: CODE_SIZE]),
    .mask_row_o (row_mask)
  );

  always_comb begin
    grid_d = grid_q;
    grid_d[row_base +: CODE_SIZE] = grid_q[row_base +: CODE_SIZE] ^ row_mask;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      grid_q  <= '0;
      cnt_q   <= '0;
      fmt_a_q <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      ecc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            grid_q  <= qr_code_in;
            cnt_q   <= '0;
            fmt_a_q <= '0;
            state_q <= FORMAT;
          end
        end
        FORMAT: begin
          fmt_a_q <= {fmt_a_q[13:0], fmt_a_bit};
          if (cnt_q == LAST_FMT) begin
            cnt_q   <= '0;
            state_q <= UNMASK;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        UNMASK: begin
          grid_q <= grid_d;
          if (cnt_q == LAST_ROW) begin
            // Outputs change only here so the previous result stays visible while busy.
            out_q   <= grid_d;
            mask_q  <= mask_id;
            ecc_q   <= ecc_id;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ready_out       = (state_q == IDLE);
  assign valid_out       = valid_q;
  assign qr_unmasked_out = out_q;
  assign mask_out        = mask_q;
  assign ecc_level_out   = ecc_q;

`ifdef FORMAT_CHECK_EN
  logic [14:0] fmt_b_q;
  logic        ferr_q;
  logic        fmt_b_bit;

  assign fmt_b_bit = grid_q[grid_idx(FMT_B_X[cnt_q[3:0]], FMT_B_Y[cnt_q[3:0]])];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fmt_b_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && valid_in)
        fmt_b_q <= '0;
      else if (state_q == FORMAT)
        fmt_b_q <= {fmt_b_q[13:0], fmt_b_bit};
      if (state_q == UNMASK && cnt_q == LAST_ROW)
        ferr_q <= (fmt_a_q != fmt_b_q);
    end
  end

  assign format_error_out = ferr_q;
`else
  assign format_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_qr_unmask.sv
// Randomized self-checking bench for qr_unmask against a behavioural grid-level reference model.
module tb_qr_unmask;

  logic         clk_in;
  logic         rst_in;
  logic [440:0] qr_code_in;
  logic         valid_in;
  logic         ready_out;
  logic [440:0] qr_unmasked_out;
  logic [2:0]   mask_out;
  logic [1:0]   ecc_level_out;
  logic         valid_out;
  logic         ready_in;
  logic         format_error_out;

  int n_cmp = 0;
  int n_mis = 0;

  // Format copy coordinates in MSB-first order.
  int ax[15] = '{0, 1, 2, 3, 4, 5, 7, 8, 8, 8, 8, 8, 8, 8, 8};
  int ay[15] = '{8, 8, 8, 8, 8, 8, 8, 8, 7, 5, 4, 3, 2, 1, 0};
  int bx[15] = '{8, 8, 8, 8, 8, 8, 8, 13, 14, 15, 16, 17, 18, 19, 20};
  int by[15] = '{20, 19, 18, 17, 16, 15, 14, 8, 8, 8, 8, 8, 8, 8, 8};

  qr_unmask #(.CODE_SIZE(21)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .qr_code_in       (qr_code_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .qr_unmasked_out  (qr_unmasked_out),
    .mask_out         (mask_out),
    .ecc_level_out    (ecc_level_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .format_error_out (format_error_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [440:0] got, input logic [440:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit mcond(input int m, input int i, input int j);
    case (m)
      0: return (i + j) % 2 == 0;
      1: return i % 2 == 0;
      2: return j % 3 == 0;
      3: return (i + j) % 3 == 0;
      4: return (i / 2 + j / 3) % 2 == 0;
      5: return (i * j) % 2 + (i * j) % 3 == 0;
      6: return ((i * j) % 2 + (i * j) % 3) % 2 == 0;
      default: return ((i + j) % 2 + (i * j) % 3) % 2 == 0;
    endcase
  endfunction

  function automatic bit is_func(input int x, input int y);
    return (y <= 8 && x <= 8) || (y <= 8 && x >= 13) || (y >= 13 && x <= 8) || y == 6 || x == 6;
  endfunction

  function automatic void ref_model(input logic [440:0] g, output logic [440:0] u,
                                    output logic [2:0] m, output logic [1:0] e, output logic fe);
    logic [14:0] a, b, w;
    for (int k = 0; k < 15; k++) begin
      a[14-k] = g[ax[k] + ay[k] * 21];
      b[14-k] = g[bx[k] + by[k] * 21];
    end
    w = a ^ 15'b101010000010010;
    e = w[14:13];
    m = w[12:10];
`ifdef FORMAT_CHECK_EN
    fe = (a != b);
`else
    fe = 1'b0;
`endif
    u = g;
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        if (!is_func(x, y) && mcond(int'(m), y, x))
          u[x + y * 21] = ~g[x + y * 21];
  endfunction

  function automatic logic [440:0] set_fmt(input logic [440:0] g, input logic [14:0] a,
                                           input logic [14:0] b, input bit put_b);
    logic [440:0] r;
    r = g;
    for (int k = 0; k < 15; k++) begin
      r[ax[k] + ay[k] * 21] = a[14-k];
      if (put_b) r[bx[k] + by[k] * 21] = b[14-k];
    end
    return r;
  endfunction

  function automatic logic [440:0] rand_grid();
    logic [440:0] g;
    for (int k = 0; k < 441; k++) g[k] = 1'($urandom_range(0, 1));
    return g;
  endfunction

  task automatic chk_result(input string tag, input logic [440:0] eu, input logic [2:0] em,
                            input logic [1:0] ee, input logic ef);
    chk({tag, "_grid"}, qr_unmasked_out, eu);
    chk({tag, "_mask"}, 441'(mask_out), 441'(em));
    chk({tag, "_ecc"}, 441'(ecc_level_out), 441'(ee));
    chk({tag, "_ferr"}, 441'(format_error_out), 441'(ef));
  endtask

  // Edge count from the accepting edge to the first sample with valid_out high.
  task automatic accept_and_wait(input logic [440:0] g, input string tag);
    int n;
    chk({tag, "_rdy"}, 441'(ready_out), 441'(1));
    qr_code_in = g;
    valid_in   = 1'b1;
    tick();
    valid_in   = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_out && n < 80);
    // Accept cycle is cycle 0, so valid in cycle 37 means 36 edges later.
    chk({tag, "_lat"}, 441'(n), 441'(36));
  endtask

  task automatic run_one(input logic [440:0] g, input int hold, input string tag);
    logic [440:0] eu;
    logic [2:0]   em;
    logic [1:0]   ee;
    logic         ef;
    ref_model(g, eu, em, ee, ef);
    accept_and_wait(g, tag);
    chk_result(tag, eu, em, ee, ef);
    ready_in = 1'b0;
    for (int k = 0; k < hold; k++) begin
      valid_in   = (k == hold / 2);
      qr_code_in = ~g;
      tick();
      chk({tag, "_hold_vld"}, 441'({valid_out, ready_out}), 441'(2'b10));
      chk({tag, "_hold_grid"}, qr_unmasked_out, eu);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk({tag, "_release"}, 441'({valid_out, ready_out}), 441'(2'b01));
    chk({tag, "_kept"}, qr_unmasked_out, eu);
  endtask

  initial begin
    logic [440:0] g, g2, eu, eu2;
    logic [2:0]   em, em2;
    logic [1:0]   ee, ee2;
    logic         ef, ef2;
    logic [14:0]  raw, word;
    int           n;

    rst_in     = 1'b1;
    valid_in   = 1'b0;
    ready_in   = 1'b0;
    qr_code_in = '0;
    repeat (2) tick();
    rst_in = 1'b0;
    chk("reset_grid", qr_unmasked_out, '0);
    chk("reset_ctl", 441'({valid_out, ready_out, mask_out, ecc_level_out, format_error_out}),
        441'(8'b01_000_00_0));

    // All-zero grid decodes to mask 5, ECC H.
    run_one('0, 2, "zero");
    chk("zero_mask5", 441'(mask_out), 441'(5));
    chk("zero_eccH", 441'(ecc_level_out), 441'(2'b10));
    chk("zero_12_9", 441'(qr_unmasked_out[12 + 9 * 21]), 441'(1));
    chk("zero_9_9", 441'(qr_unmasked_out[9 + 9 * 21]), 441'(0));
    chk("zero_row6", 441'(qr_unmasked_out[6 * 21 +: 21]), 441'(0));

    // Copy A only: ECC L, mask 0.
    raw = 15'b111011111000100;
    run_one(set_fmt('0, raw, '0, 1'b0), 1, "fmtA");
    chk("fmtA_eccL", 441'(ecc_level_out), 441'(2'b01));
    chk("fmtA_mask0", 441'(mask_out), 441'(0));
    chk("fmtA_9_9", 441'(qr_unmasked_out[9 + 9 * 21]), 441'(1));
    chk("fmtA_10_9", 441'(qr_unmasked_out[10 + 9 * 21]), 441'(0));

    // Every mask pattern over random data; copy B matches on even IDs.
    for (int m = 0; m < 8; m++) begin
      word = 15'($urandom);
      word[12:10] = 3'(m);
      raw = word ^ 15'b101010000010010;
      run_one(set_fmt(rand_grid(), raw, raw, (m % 2) == 0), int'($urandom_range(0, 3)), "mask");
      chk("mask_id", 441'(mask_out), 441'(m));
    end

    // Long stall in DONE with a stray valid_in pulse.
    run_one(rand_grid(), 10, "stall");

    // Fully random grids.
    for (int k = 0; k < 4; k++) run_one(rand_grid(), int'($urandom_range(0, 4)), "rand");

    // Reset in the middle of UNMASK, then a fresh grid.
    qr_code_in = rand_grid();
    valid_in   = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (20) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_grid", qr_unmasked_out, '0);
    chk("midrst_ctl", 441'({valid_out, ready_out, mask_out, ecc_level_out, format_error_out}),
        441'(8'b01_000_00_0));
    run_one(rand_grid(), 1, "after_rst");

    // Back-to-back: second grid waits on valid_in through DONE.
    g  = rand_grid();
    g2 = rand_grid();
    ref_model(g, eu, em, ee, ef);
    ref_model(g2, eu2, em2, ee2, ef2);
    accept_and_wait(g, "b2b1");
    chk_result("b2b1", eu, em, ee, ef);
    ready_in   = 1'b1;
    valid_in   = 1'b1;
    qr_code_in = g2;
    tick();
    chk("b2b_idle", 441'({valid_out, ready_out}), 441'(2'b01));
    tick();
    valid_in = 1'b0;
    ready_in = 1'b0;
    chk("b2b_busy", 441'(ready_out), 441'(0));
    n = 2;
    while (!valid_out && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_gap", 441'(n), 441'(38));
    chk_result("b2b2", eu2, em2, ee2, ef2);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("b2b_release", 441'({valid_out, ready_out}), 441'(2'b01));

`ifdef FORMAT_CHECK_EN
    // Copy B differs in bit 3: error flagged, decode still from copy A.
    raw = 15'($urandom);
    run_one(set_fmt(rand_grid(), raw, raw ^ 15'h0008, 1'b1), 1, "copyB");
    chk("copyB_err", 441'(format_error_out), 441'(1));
    word = raw ^ 15'b101010000010010;
    chk("copyB_maskA", 441'(mask_out), 441'(word[12:10]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
